instruction_sequencer: RTL and testbench

Issue controller between the instruction memory and the execution units. After `start`, it releases the program length to the instruction memory. It then pulls instructions one per cycle and routes each to the execution unit named in its header, using a valid/ready handshake. It enforces barrier and halt semantics and per-unit outstanding limits, and reports completion once every issued instruction has retired.

---
 rtl/instruction_sequencer.sv | 125 ++++++++++++
 tb/tb_instruction_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Issue controller: pulls instructions from the instruction memory and hands each
// to the execution unit named in its header, honouring barrier/halt and per-unit credit.
module instruction_sequencer #(
  parameter int INST_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int UNIT_W  = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           program_length,
  output logic [ADDR_W-1:0]           instruction_count,
  input  logic [INST_W-1:0]           inst,
  input  logic                        inst_valid,
  output logic                        advance_pointer,
  output logic [(1<<UNIT_W)-1:0]      dispatch_valid,
  input  logic [(1<<UNIT_W)-1:0]      dispatch_ready,
  output logic [INST_W-1:0]           dispatch_inst,
  input  logic [(1<<UNIT_W)-1:0]      unit_done,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int NUM_UNITS = 1 << UNIT_W;
  localparam int CNT_W     = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      outstanding [NUM_UNITS];
  logic [UNIT_W-1:0]     hdr_unit;
  logic                  hdr_barrier;
  logic                  hdr_halt;
  logic                  all_idle;
  logic                  eligible;
  logic [NUM_UNITS-1:0]  xfer_vec;
  logic [NUM_UNITS-1:0]  underflow_vec;

  // Credit update: a simultaneous issue and retire cancel; a retire at zero clamps.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      res = cnt - CNT_W'(1);
    return res;
  endfunction

  assign hdr_unit    = inst[INST_W-1 -: UNIT_W];
  assign hdr_barrier = inst[INST_W-UNIT_W-1];
  assign hdr_halt    = inst[INST_W-UNIT_W-2];

  always_comb begin
    all_idle      = 1'b1;
    underflow_vec = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (outstanding[u] != '0)
        all_idle = 1'b0;
      underflow_vec[u] = unit_done[u] && !xfer_vec[u] && (outstanding[u] == '0);
    end
  end

  // Eligibility only depends on counters that can merely fall during a stall,
  // so a raised dispatch_valid stays up until the unit accepts.
  always_comb begin
    eligible = (state == S_ISSUE) && inst_valid && !hdr_halt &&
               (!hdr_barrier || all_idle) &&
               (outstanding[hdr_unit] < CNT_W'(MAX_OUT));
    dispatch_valid = eligible ? (NUM_UNITS'(1) << hdr_unit) : '0;
  end

  assign xfer_vec        = dispatch_valid & dispatch_ready;
  assign advance_pointer = |xfer_vec;
  assign dispatch_inst   = inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      instruction_count <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++)
        outstanding[u] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_ISSUE;
            busy              <= 1'b1;
            instruction_count <= program_length;
          end
        end
        S_ISSUE: begin
          if (!inst_valid || hdr_halt)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (all_idle) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase

      for (int u = 0; u < NUM_UNITS; u++)
        outstanding[u] <= next_count(outstanding[u], xfer_vec[u], unit_done[u]);

      if (|underflow_vec)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: instruction memory model, delayed-retire unit model,
// a dispatch scoreboard, a decode vector table and hand-written corner sequences.
module tb_instruction_sequencer;

  localparam int INST_W = 64;
  localparam int ADDR_W = 8;
  localparam int UNIT_W = 2;
  localparam int NU     = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] program_length;
  logic [ADDR_W-1:0] instruction_count;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              advance_pointer;
  logic [NU-1:0]     dispatch_valid;
  logic [NU-1:0]     dispatch_ready;
  logic [INST_W-1:0] dispatch_inst;
  logic [NU-1:0]     unit_done;
  logic              busy;
  logic              done;
  logic              error;

  instruction_sequencer #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .UNIT_W(UNIT_W), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .program_length(program_length),
    .instruction_count(instruction_count), .inst(inst), .inst_valid(inst_valid),
    .advance_pointer(advance_pointer), .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready), .dispatch_inst(dispatch_inst),
    .unit_done(unit_done), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: word at pc is valid while pc is below the released count.
  logic [INST_W-1:0] mem [256];
  logic [7:0]        pc;
  assign inst       = mem[pc];
  assign inst_valid = (pc < instruction_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (advance_pointer) pc <= pc + 8'd1;
  end

  // Execution units: optionally retire each accepted instruction two cycles later.
  logic          auto_done;
  logic [NU-1:0] man_done;
  logic [NU-1:0] xd1, xd2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xd1 <= '0;
      xd2 <= '0;
    end else begin
      xd1 <= dispatch_valid & dispatch_ready;
      xd2 <= xd1;
    end
  end
  assign unit_done = (auto_done ? xd2 : '0) | man_done;

  typedef struct packed {
    logic [NU-1:0]     dv;
    logic [INST_W-1:0] word;
  } exp_t;
  exp_t sb[$];

  logic          pend;
  logic [NU-1:0] pend_dv;

  // Monitor: one-hot, advance tracks transfer, no valid withdrawal, scoreboard order.
  always @(negedge clk) begin
    logic [NU-1:0] xv;
    exp_t e;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      xv = dispatch_valid & dispatch_ready;
      if (dispatch_valid != '0)
        chk("onehot_dv", 64'($onehot(dispatch_valid)), 64'd1);
      chk("adv_eq_xfer", 64'(advance_pointer), 64'(xv != '0));
      if (pend)
        chk("dv_held", 64'(dispatch_valid), 64'(pend_dv));
      if (xv != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'(dispatch_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_unit", 64'(dispatch_valid), 64'(e.dv));
          chk("sb_inst", dispatch_inst, e.word);
        end
      end
      pend    = (dispatch_valid != '0) && (xv == '0);
      pend_dv = dispatch_valid;
    end
  end

  function automatic logic [63:0] mk(input int u, input bit b, input bit h, input int pay);
    logic [1:0]  uu;
    logic [31:0] pp;
    uu = u[1:0];
    pp = pay;
    return {uu, b, h, 28'h0, pp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    program_length = '0;
    dispatch_ready = '0;
    man_done       = '0;
    auto_done      = 1'b0;
    sb.delete();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic start_prog(input int len);
    program_length = ADDR_W'(len);
    start          = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else step();
    end
    chk("done_reached", 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [INST_W-1:0] word;
    logic [NU-1:0]     exp_dv;
  } vec_t;
  vec_t vt [6];

  initial begin
    vt[0] = '{mk(0, 0, 0, 32'h100), 4'b0001};
    vt[1] = '{mk(1, 0, 0, 32'h101), 4'b0010};
    vt[2] = '{mk(2, 0, 0, 32'h102), 4'b0100};
    vt[3] = '{mk(3, 1, 0, 32'h103), 4'b1000};
    vt[4] = '{mk(2, 0, 1, 32'h104), 4'b0000};
    vt[5] = '{mk(1, 1, 1, 32'h105), 4'b0000};

    // Reset state
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(instruction_count), 64'd0);
    chk("rst_adv",   64'(advance_pointer),   64'd0);
    chk("rst_dv",    64'(dispatch_valid),    64'd0);
    chk("rst_busy",  64'(busy),              64'd0);
    chk("rst_done",  64'(done),              64'd0);
    chk("rst_error", 64'(error),             64'd0);

    // Single-instruction decode vectors
    for (int v = 0; v < 6; v++) begin
      do_reset();
      mem[0]         = vt[v].word;
      dispatch_ready = '1;
      auto_done      = 1'b1;
      if (vt[v].exp_dv != '0) sb.push_back('{vt[v].exp_dv, vt[v].word});
      start_prog(1);
      @(negedge clk);
      chk($sformatf("vec%0d_dv", v),   64'(dispatch_valid),  64'(vt[v].exp_dv));
      chk($sformatf("vec%0d_adv", v),  64'(advance_pointer), 64'(vt[v].exp_dv != '0));
      chk($sformatf("vec%0d_busy", v), 64'(busy),            64'd1);
      step();
      wait_done(12);
      chk($sformatf("vec%0d_err", v), 64'(error), 64'd0);
      chk($sformatf("vec%0d_sb", v),  64'(sb.size()), 64'd0);
    end

    // Zero-length program: done three cycles after start
    do_reset();
    start_prog(0);
    @(negedge clk);
    chk("len0_busy_t1", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("len0_done_t2", 64'(done), 64'd0);
    step();
    @(negedge clk);
    chk("len0_done_t3", 64'(done), 64'd1);

    // Three instructions, retire two cycles after issue
    do_reset();
    mem[0] = mk(0, 0, 0, 32'hA0);
    mem[1] = mk(1, 0, 0, 32'hA1);
    mem[2] = mk(2, 0, 0, 32'hA2);
    sb.push_back('{4'b0001, mem[0]});
    sb.push_back('{4'b0010, mem[1]});
    sb.push_back('{4'b0100, mem[2]});
    dispatch_ready = '1;
    auto_done      = 1'b1;
    start_prog(3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) chk("a_count", 64'(instruction_count), 64'd3);
      if (k <= 3) chk($sformatf("a_adv_t%0d", k), 64'(advance_pointer), 64'd1);
      if (k == 4) chk("a_adv_t4", 64'(advance_pointer), 64'd0);
      if (k == 6) chk("a_done_t6", 64'(done), 64'd0);
      if (k == 7) begin
        chk("a_done_t7", 64'(done), 64'd1);
        chk("a_busy_t7", 64'(busy), 64'd0);
      end
      step();
    end
    chk("a_sb", 64'(sb.size()), 64'd0);

    // Unit 1 holds ready low for five cycles
    do_reset();
    mem[0] = mk(1, 0, 0, 32'hB0);
    mem[1] = mk(0, 0, 0, 32'hB1);
    sb.push_back('{4'b0010, mem[0]});
    sb.push_back('{4'b0001, mem[1]});
    dispatch_ready = 4'b1101;
    auto_done      = 1'b1;
    start_prog(2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("b_dv_t%0d", k),  64'(dispatch_valid),  64'h2);
      chk($sformatf("b_adv_t%0d", k), 64'(advance_pointer), 64'd0);
      step();
    end
    dispatch_ready = '1;
    @(negedge clk);
    chk("b_xfer_dv",  64'(dispatch_valid),  64'h2);
    chk("b_xfer_adv", 64'(advance_pointer), 64'd1);
    step();
    @(negedge clk);
    chk("b_next_dv", 64'(dispatch_valid), 64'h1);
    step();
    wait_done(12);
    chk("b_sb", 64'(sb.size()), 64'd0);

    // Outstanding limit on unit 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem[i] = mk(0, 0, 0, 32'hC0 + i);
      sb.push_back('{4'b0001, mem[i]});
    end
    dispatch_ready = '1;
    start_prog(5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("c_adv_t%0d", k), 64'(advance_pointer), 64'd1);
      step();
    end
    for (int k = 5; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("c_stall_adv_t%0d", k), 64'(advance_pointer), 64'd0);
      chk($sformatf("c_stall_dv_t%0d", k),  64'(dispatch_valid),  64'd0);
      step();
    end
    man_done = 4'b0001;
    @(negedge clk);
    chk("c_adv_done_cycle", 64'(advance_pointer), 64'd0);
    step();
    man_done = '0;
    @(negedge clk);
    chk("c_fifth_issue", 64'(advance_pointer), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      man_done = 4'b0001;
      step();
    end
    man_done = '0;
    wait_done(12);
    chk("c_err", 64'(error), 64'd0);
    chk("c_sb", 64'(sb.size()), 64'd0);

    // Barrier waits for every unit to drain
    do_reset();
    mem[0] = mk(2, 0, 0, 32'hD0);
    mem[1] = mk(3, 1, 0, 32'hD1);
    sb.push_back('{4'b0100, mem[0]});
    sb.push_back('{4'b1000, mem[1]});
    dispatch_ready = '1;
    start_prog(2);
    @(negedge clk);
    chk("d_first_dv", 64'(dispatch_valid), 64'h4);
    step();
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("d_block_t%0d", k), 64'(dispatch_valid), 64'd0);
      step();
    end
    man_done = 4'b0100;
    @(negedge clk);
    chk("d_block_donecyc", 64'(dispatch_valid), 64'd0);
    step();
    man_done = '0;
    @(negedge clk);
    chk("d_barrier_dv",  64'(dispatch_valid),  64'h8);
    chk("d_barrier_adv", 64'(advance_pointer), 64'd1);
    step();
    man_done = 4'b1000;
    step();
    man_done = '0;
    wait_done(12);
    chk("d_err", 64'(error), 64'd0);
    chk("d_sb", 64'(sb.size()), 64'd0);

    // Halt stops issue; stray retire sets sticky error; start ignored in DONE
    do_reset();
    mem[0] = mk(0, 0, 0, 32'hE0);
    mem[1] = mk(1, 0, 0, 32'hE1);
    mem[2] = mk(2, 0, 1, 32'hE2);
    mem[3] = mk(3, 0, 0, 32'hE3);
    sb.push_back('{4'b0001, mem[0]});
    sb.push_back('{4'b0010, mem[1]});
    dispatch_ready = '1;
    auto_done      = 1'b1;
    start_prog(4);
    step();
    step();
    @(negedge clk);
    chk("e_halt_dv",  64'(dispatch_valid),  64'd0);
    chk("e_halt_adv", 64'(advance_pointer), 64'd0);
    step();
    wait_done(12);
    chk("e_sb", 64'(sb.size()), 64'd0);
    chk("e_err_before", 64'(error), 64'd0);
    step();
    man_done = 4'b1000;
    step();
    man_done = '0;
    @(negedge clk);
    chk("e_err_set", 64'(error), 64'd1);
    step();
    step();
    @(negedge clk);
    chk("e_err_sticky", 64'(error), 64'd1);
    step();
    program_length = 8'd9;
    start          = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("e_done_start_done",  64'(done),              64'd1);
    chk("e_done_start_count", 64'(instruction_count), 64'd4);
    chk("e_done_start_busy",  64'(busy),              64'd0);

    // Second start during ISSUE ignored; asynchronous reset mid-stall
    do_reset();
    mem[0] = mk(1, 0, 0, 32'hF0);
    mem[1] = mk(1, 0, 0, 32'hF1);
    mem[2] = mk(0, 0, 0, 32'hF2);
    dispatch_ready = 4'b1101;
    start_prog(3);
    program_length = 8'd7;
    start          = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("f_count_kept", 64'(instruction_count), 64'd3);
    chk("f_busy",       64'(busy),              64'd1);
    chk("f_stall_dv",   64'(dispatch_valid),    64'h2);
    chk("f_stall_adv",  64'(advance_pointer),   64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_async_dv",    64'(dispatch_valid),    64'd0);
    chk("f_async_adv",   64'(advance_pointer),   64'd0);
    chk("f_async_busy",  64'(busy),              64'd0);
    chk("f_async_count", 64'(instruction_count), 64'd0);
    chk("f_async_done",  64'(done),              64'd0);
    chk("f_async_err",   64'(error),             64'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("f_sb", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
